// File: rtl/matrix_mul_pkg.sv
// ============================================================================
// Module   : matrix_mul_pkg
// Purpose  : Shared types and constants for the matrix-multiply datapath:
//            accumulator FSM state encoding, lane index type, lane order
//            and the fixed accumulate latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_mul_pkg;

    // Accumulator sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

    // Index of one of the four 2x2 block lanes.
    typedef logic [1:0] lane_t;

    // Lane order used by the sequencer and the writeback.
    localparam lane_t C_LANE_11 = 2'd0;
    localparam lane_t C_LANE_12 = 2'd1;
    localparam lane_t C_LANE_21 = 2'd2;
    localparam lane_t C_LANE_22 = 2'd3;

    // Cycles from the accepted start edge to the final lane write.
    // Follows from 4 issue cycles + 2 pipeline stages; fixed by structure.
    localparam int ACC_LATENCY = 6;

endpackage : matrix_mul_pkg

`default_nettype wire

// File: rtl/acc_add_pipe.sv
// ============================================================================
// Module   : acc_add_pipe
// Purpose  : Two-stage signed adder shared by the four accumulator lanes.
//            Stage 1 registers the operands with their lane tag and valid
//            bit; stage 2 registers the DATA_W+1 bit sum. Overflow detect
//            and the optional clamp act on the stage-2 register, so the
//            caller writes the result back on the following edge.
// Config   : MATRIX_ACC_SAT_EN - when defined, an overflowing result is
//            clamped to the most positive/negative value instead of wrapping.
// Ports    : clk, rst        clock / synchronous active-high reset
//            i_flush         drop everything in flight (valid bits cleared)
//            i_valid/i_lane  issue strobe and lane tag
//            i_a, i_b        signed operands
//            o_valid/o_lane  stage-2 result strobe and lane tag
//            o_sum           wrapped or clamped result
//            o_ovf           signed overflow of the stage-2 result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_add_pipe
    import matrix_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  lane_t                    i_lane,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic                     o_valid,
    output lane_t                    o_lane,
    output logic signed [DATA_W-1:0] o_sum,
    output logic                     o_ovf
);

    logic              r_s1_valid;
    lane_t             r_s1_lane;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;

    logic              r_s2_valid;
    lane_t             r_s2_lane;
    logic [DATA_W:0]   r_s2_sum;

    logic [DATA_W:0]   w_sum_ext;
    logic              w_ovf;

    // Sign-extend both operands so the extra bit carries the true sign.
    assign w_sum_ext = {r_s1_a[DATA_W-1], r_s1_a} + {r_s1_b[DATA_W-1], r_s1_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid & ~i_flush;
            r_s2_valid <= r_s1_valid & ~i_flush;
        end
        r_s1_lane <= i_lane;
        r_s1_a    <= i_a;
        r_s1_b    <= i_b;
        r_s2_lane <= r_s1_lane;
        r_s2_sum  <= w_sum_ext;
    end

    // Same-sign operands with a differing result sign show up as the
    // extended sign bit disagreeing with the DATA_W-bit sign.
    assign w_ovf = r_s2_sum[DATA_W] ^ r_s2_sum[DATA_W-1];

`ifdef MATRIX_ACC_SAT_EN
    always_comb begin
        o_sum = r_s2_sum[DATA_W-1:0];
        if (w_ovf) begin
            o_sum = r_s2_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign o_sum = r_s2_sum[DATA_W-1:0];
`endif

    assign o_valid = r_s2_valid;
    assign o_lane  = r_s2_lane;
    assign o_ovf   = w_ovf;

endmodule : acc_add_pipe

`default_nettype wire

// File: rtl/matrix_block_acc.sv
// ============================================================================
// Module   : matrix_block_acc
// Purpose  : Accumulates successive 2x2 partial-product blocks into four
//            running sums using one time-multiplexed 2-stage adder.
//            A rising edge on start_acc snapshots c_* and issues lanes
//            11,12,21,22 on consecutive cycles; the last lane is written
//            ACC_LATENCY cycles after the accepted edge and done_acc pulses.
// Config   : MATRIX_ACC_SAT_EN - saturating instead of wrapping sums.
// Ports    : clk, rst              clock / synchronous active-high reset
//            start_acc             level; rising edge requests accumulation
//            reset_acc             level; clears sums, aborts if busy
//            c_11..c_22            partial block to add (signed)
//            acc_11..acc_22        registered running sums
//            done_acc              one-cycle completion pulse
//            busy                  accumulation in flight
//            ovf                   sticky overflow, any lane (rst clears)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_block_acc
    import matrix_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_acc,
    input  logic                     reset_acc,
    input  logic signed [DATA_W-1:0] c_11,
    input  logic signed [DATA_W-1:0] c_12,
    input  logic signed [DATA_W-1:0] c_21,
    input  logic signed [DATA_W-1:0] c_22,
    output logic signed [DATA_W-1:0] acc_11,
    output logic signed [DATA_W-1:0] acc_12,
    output logic signed [DATA_W-1:0] acc_21,
    output logic signed [DATA_W-1:0] acc_22,
    output logic                     done_acc,
    output logic                     busy,
    output logic                     ovf
);

    acc_state_t               r_state;
    acc_state_t               w_state_nxt;
    lane_t                    r_lane;
    lane_t                    w_lane_nxt;
    logic                     r_start_q;
    logic                     r_done;
    logic                     r_ovf;
    logic                     w_start_edge;
    logic                     w_accept;
    logic                     w_issue;
    logic                     w_done_nxt;

    logic signed [DATA_W-1:0] r_acc  [4];
    logic signed [DATA_W-1:0] r_snap [4];

    logic                     w_pipe_valid;
    lane_t                    w_pipe_lane;
    logic signed [DATA_W-1:0] w_pipe_sum;
    logic                     w_pipe_ovf;

    assign w_start_edge = start_acc & ~r_start_q;
    assign w_accept     = w_start_edge & (r_state == IDLE) & ~reset_acc;

    // Next-state logic. r_lane doubles as the drain cycle counter.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                    w_lane_nxt  = C_LANE_11;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                if (r_lane == C_LANE_22) begin
                    w_state_nxt = DRAIN;
                    w_lane_nxt  = 2'd0;
                end else begin
                    w_lane_nxt = r_lane + 2'd1;
                end
            end
            DRAIN: begin
                if (r_lane == 2'd1) begin
                    w_state_nxt = IDLE;
                    w_lane_nxt  = 2'd0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_lane_nxt = r_lane + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_lane_nxt  = 2'd0;
            end
        endcase
        // reset_acc aborts any operation and swallows a coincident start.
        if (reset_acc) begin
            w_state_nxt = IDLE;
            w_lane_nxt  = 2'd0;
            w_issue     = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lane    <= 2'd0;
            r_start_q <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_lane    <= w_lane_nxt;
            r_start_q <= start_acc;
            r_done    <= w_done_nxt;
            if (reset_acc) begin
                for (int i = 0; i < 4; i++) begin
                    r_acc[i] <= '0;
                end
            end else if (w_pipe_valid) begin
                r_acc[w_pipe_lane] <= w_pipe_sum;
                if (w_pipe_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Snapshot lets the producer change c_* as soon as the start is taken.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_snap[C_LANE_11] <= c_11;
            r_snap[C_LANE_12] <= c_12;
            r_snap[C_LANE_21] <= c_21;
            r_snap[C_LANE_22] <= c_22;
        end
    end

    acc_add_pipe #(
        .DATA_W (DATA_W)
    ) u_add_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (reset_acc),
        .i_valid (w_issue),
        .i_lane  (r_lane),
        .i_a     (r_acc[r_lane]),
        .i_b     (r_snap[r_lane]),
        .o_valid (w_pipe_valid),
        .o_lane  (w_pipe_lane),
        .o_sum   (w_pipe_sum),
        .o_ovf   (w_pipe_ovf)
    );

    assign acc_11   = r_acc[C_LANE_11];
    assign acc_12   = r_acc[C_LANE_12];
    assign acc_21   = r_acc[C_LANE_21];
    assign acc_22   = r_acc[C_LANE_22];
    assign done_acc = r_done;
    assign busy     = (r_state != IDLE);
    assign ovf      = r_ovf;

endmodule : matrix_block_acc

`default_nettype wire

// File: tb/tb_matrix_block_acc.sv
// ============================================================================
// Module   : tb_matrix_block_acc
// Purpose  : Directed self-checking bench for matrix_block_acc with
//            hand-computed expected sums, latency, abort and overflow cases.
//            Build with MATRIX_ACC_SAT_EN defined to check the clamp build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_block_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_acc;
    logic        reset_acc;
    logic [31:0] c_11, c_12, c_21, c_22;
    logic [31:0] acc_11, acc_12, acc_21, acc_22;
    logic        done_acc;
    logic        busy;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    matrix_block_acc #(
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_acc (start_acc),
        .reset_acc (reset_acc),
        .c_11      (c_11),
        .c_12      (c_12),
        .c_21      (c_21),
        .c_22      (c_22),
        .acc_11    (acc_11),
        .acc_12    (acc_12),
        .acc_21    (acc_21),
        .acc_22    (acc_22),
        .done_acc  (done_acc),
        .busy      (busy),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic [31:0] a, b, c, d);
        c_11 = a; c_12 = b; c_21 = c; c_22 = d;
    endtask

    task automatic check_acc(input string tag, input logic [31:0] a, b, c, d);
        check({tag, "_11"}, acc_11, a);
        check({tag, "_12"}, acc_12, b);
        check({tag, "_21"}, acc_21, c);
        check({tag, "_22"}, acc_22, d);
    endtask

    task automatic clear_acc();
        reset_acc = 1'b1;
        tick();
        reset_acc = 1'b0;
    endtask

    // One full accumulation with a bounded wait on done_acc.
    task automatic run_acc(input string tag, input logic [31:0] a, b, c, d);
        logic seen;
        seen = 1'b0;
        set_c(a, b, c, d);
        start_acc = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (done_acc) seen = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        start_acc = 1'b0;
        tick();
    endtask

    initial begin
        int dones;
        rst = 1'b1; start_acc = 1'b0; reset_acc = 1'b0;
        set_c(0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_acc("rst_acc", 0, 0, 0, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done_acc}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);

        // Latency: lanes written at E3..E6, done in the cycle after E6
        set_c(1, 2, 3, 4);
        start_acc = 1'b1;
        tick(); // E0
        check("lat_busy_e0", {31'd0, busy}, 1);
        check("lat_acc11_e0", acc_11, 0);
        tick(); tick(); // E2
        check("lat_acc11_e2", acc_11, 0);
        check("lat_busy_e2", {31'd0, busy}, 1);
        tick(); // E3
        check("lat_acc11_e3", acc_11, 1);
        check("lat_acc12_e3", acc_12, 0);
        tick(); // E4
        check("lat_acc12_e4", acc_12, 2);
        check("lat_acc21_e4", acc_21, 0);
        tick(); // E5
        check("lat_acc21_e5", acc_21, 3);
        check("lat_acc22_e5", acc_22, 0);
        check("lat_done_e5", {31'd0, done_acc}, 0);
        check("lat_busy_e5", {31'd0, busy}, 1);
        tick(); // E6
        check("lat_acc22_e6", acc_22, 4);
        check("lat_done_e6", {31'd0, done_acc}, 1);
        check("lat_busy_e6", {31'd0, busy}, 0);
        start_acc = 1'b0;
        tick(); // E7
        check("lat_done_e7", {31'd0, done_acc}, 0);

        // Three back-to-back accumulations
        clear_acc();
        check_acc("clr", 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) run_acc("b2b", 5, -32'sd3, 7, 0);
        check_acc("b2b", 15, -32'sd9, 21, 0);
        clear_acc();
        check_acc("b2b_clr", 0, 0, 0, 0);
        check("b2b_clr_ovf", {31'd0, ovf}, 0);

        // Level held high 20 cycles: exactly one accumulation
        set_c(1, 2, 3, 4);
        start_acc = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_acc) dones++;
        end
        start_acc = 1'b0;
        tick();
        check("hold_dones", dones, 1);
        check_acc("hold", 1, 2, 3, 4);

        // Second rising edge at E3 while busy is ignored
        clear_acc();
        start_acc = 1'b1;
        dones = 0;
        tick(); // E0
        tick(); // E1
        start_acc = 1'b0;
        tick(); // E2
        start_acc = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (done_acc) dones++;
        end
        start_acc = 1'b0;
        tick();
        check("busyedge_dones", dones, 1);
        check_acc("busyedge", 1, 2, 3, 4);

        // reset_acc at E4 aborts
        clear_acc();
        set_c(10, 20, 30, 40);
        start_acc = 1'b1;
        tick(); tick(); tick(); tick(); // E0..E3
        check("abort_acc11_e3", acc_11, 10);
        reset_acc = 1'b1;
        tick(); // E4
        reset_acc = 1'b0;
        start_acc = 1'b0;
        check_acc("abort", 0, 0, 0, 0);
        check("abort_busy", {31'd0, busy}, 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_acc) dones++;
            tick();
        end
        check("abort_dones", dones, 0);
        check_acc("abort_late", 0, 0, 0, 0);
        run_acc("after_abort", 1, 1, 1, 1);
        check_acc("after_abort", 1, 1, 1, 1);

        // Positive overflow on lane 11
        clear_acc();
        run_acc("ovf_a", 32'h7FFF_FFFF, 5, 0, 0);
        check("ovf_pre", {31'd0, ovf}, 0);
        run_acc("ovf_b", 1, 0, 0, 0);
`ifdef MATRIX_ACC_SAT_EN
        check_acc("ovf_pos", 32'h7FFF_FFFF, 5, 0, 0);
`else
        check_acc("ovf_pos", 32'h8000_0000, 5, 0, 0);
`endif
        check("ovf_set", {31'd0, ovf}, 1);

        // Negative overflow on lane 22
        clear_acc();
        check("ovf_sticky", {31'd0, ovf}, 1);
        run_acc("neg_a", 0, 0, 0, 32'h8000_0000);
        run_acc("neg_b", 0, 0, 0, 32'hFFFF_FFFF);
`ifdef MATRIX_ACC_SAT_EN
        check_acc("ovf_neg", 0, 0, 0, 32'h8000_0000);
`else
        check_acc("ovf_neg", 0, 0, 0, 32'h7FFF_FFFF);
`endif

        // Inputs changing after E0 have no effect
        clear_acc();
        set_c(100, 200, 300, 400);
        start_acc = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_acc) dones++;
            if (i < 5) set_c($urandom, $urandom, $urandom, $urandom);
        end
        start_acc = 1'b0;
        tick();
        check("snap_dones", dones, 1);
        check_acc("snap", 100, 200, 300, 400);

        // rst in mid-operation: no later lane writes, no done
        set_c(1, 1, 1, 1);
        start_acc = 1'b1;
        tick(); tick(); tick(); // E0..E2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_acc = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_acc) dones++;
        end
        check("midrst_dones", dones, 0);
        check_acc("midrst", 0, 0, 0, 0);
        check("midrst_ovf", {31'd0, ovf}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_matrix_block_acc

`default_nettype wire

// File: doc/matrix_block_acc.md
Name: matrix_block_acc

Overview:
- Downstream neighbour of the matrix-multiply control unit.
- Accumulates successive 2x2 partial-product blocks (c_11..c_22 from the 2x2 MAC, forwarded by the control unit as res_11..res_22) into four running sums acc_11..acc_22.
- The control unit writes those sums to RAM after the last k-step.
- Uses one shared 2-stage pipelined adder, time-multiplexed over the four lanes. Fixed latency fits inside the control unit's accumulate wait window.

Parameters:
- data_w, 32, element width; two's-complement signed.
- ACC_LATENCY, 6, cycles from accepted start edge to final lane write (derived constant; documented, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_acc  in  1  level from control unit; a rising edge requests one accumulation
- reset_acc  in  1  level; clears all sums while high
- c_11,c_12,c_21,c_22  in  data_w each  partial block to add
- acc_11,acc_12,acc_21,acc_22  out  data_w each  running sums, registered
- done_acc  out  1  one-cycle pulse when all four lanes are updated
- busy  out  1  accumulation in flight
- ovf  out  1  sticky overflow flag, any lane

Behaviour:
- Reset (rst=1 at clk edge): acc_* = 0, done_acc = 0, busy = 0, ovf = 0, state = IDLE, start_q = 0, pipeline valid bits = 0. rst overrides everything, including a mid-operation reset; no partial lane writes after it.
- start_q registers start_acc every cycle.
- Accepted start: start_acc=1, start_q=0, state=IDLE, reset_acc=0.
  - On that edge (E0): snapshot c_* into snap_*; busy goes 1; state goes ISSUE with lane = 0.
- Lane order: 0=11, 1=12, 2=21, 3=22.
- States:
  - IDLE.
  - ISSUE: 4 cycles, lane 0..3. Each cycle drives S1 operands {acc[lane], snap[lane], lane}.
  - DRAIN: 2 cycles, pipeline empties. Then back to IDLE.
- Adder pipeline:
  - S1 registers operands.
  - S2 registers the sum (data_w+1 bits internally).
  - The writeback to acc[lane] happens on the edge after S2.
  - Result: acc_11 updates at E3, acc_12 at E4, acc_21 at E5, acc_22 at E6.
- Outputs at E6: done_acc = 1 (for exactly one cycle), busy = 0.
- Start edge while busy: ignored (not queued). A level held high across completion does not retrigger, because an edge is required.
- reset_acc=1 while IDLE: acc_* = 0 on each edge. ovf is not cleared (only rst clears it).
- reset_acc rises while busy: abort.
  - Clear acc_* and pipeline valid bits; state = IDLE; busy = 0; no done_acc.
- reset_acc and a start edge in the same cycle: reset wins; the start edge is consumed and dropped.
- Arithmetic:
  - Sum is computed in data_w+1 bits.
  - Overflow when the two operands have the same sign and the result sign differs. Overflow sets ovf.
  - Default: the stored value wraps (low data_w bits).
- Inputs c_* may change after E0 without effect, because of the snapshot.

Optional Feature:
- Macro MATRIX_ACC_SAT_EN.
- Defined: on overflow the lane is clamped to +2^(data_w-1)-1 or -2^(data_w-1); ovf is still set.
- Undefined: two's-complement wrap; no clamp logic synthesized.
- Latency is identical in both builds.

Decomposition:
- Shared package matrix_mul_pkg holds:
  - acc state enum {IDLE, ISSUE, DRAIN}
  - 2-bit lane index typedef
  - ACC_LATENCY = 6
  - lane-order constants
- One sub-module: acc_add_pipe. It is the 2-stage adder with overflow detect and the MATRIX_ACC_SAT_EN clamp; it carries the lane tag and valid bit.
- The FSM, snapshot registers and lane writeback stay in matrix_block_acc.

Test Plan:
- rst, then c_*={1,2,3,4}, start_acc rising at E0: acc_11=1 at E3, acc_12=2 at E4, acc_21=3 at E5, acc_22=4 at E6; done_acc high only in the cycle after E6; busy high E0..E6.
- Three back-to-back accumulations of {5,-3,7,0}, each start a new rising edge after done_acc: acc = {15,-9,21,0}; then reset_acc pulse gives all acc 0 and ovf unchanged.
- start_acc held high 20 cycles: exactly one accumulation and one done_acc; a second edge at E3 during busy is ignored.
- reset_acc asserted at E4 of an accumulation: all acc 0 next edge, no done_acc, busy 0; a subsequent start works normally.
- data_w=32, acc_11=0x7FFFFFFF, c_11=1: wrap build gives 0x80000000 and ovf=1; MATRIX_ACC_SAT_EN build gives 0x7FFFFFFF and ovf=1; other lanes are unaffected.
- Change c_* to random values at E1..E5 after start: sums reflect only the E0 snapshot.
